// File: rtl/core_pkg.sv
// Shared definitions for the RV64I pipeline: ALUOp encodings, funct width and
// the bundle of decoded control signals carried between stages.
package core_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam int FUNCT_W = 4;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // An instruction that is not valid must never carry live control into EX.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
    return valid ? c : CTRL_NOP;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_sat_counter.sv
// Saturating up-counter: steps by one when inc is set and hold is clear,
// sticks at all-ones and never wraps. Only reset clears it.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;
  logic             w_step;

  assign w_step = inc && !hold && (r_count != '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_step) begin
      r_count <= r_count + ONE;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with hazard stall/flush and a saturating count of
// bubbles entering EX. Every output comes straight from a flop.
module id_ex_stage_reg
  import core_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [DATA_W-1:0]  id_rs1_data,
  input  logic [DATA_W-1:0]  id_rs2_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_instr30,
  input  logic [2:0]         id_funct3,
  input  logic               id_reg_write,
  input  logic               id_mem_to_reg,
  input  logic               id_branch,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_alu_src,
  input  logic [1:0]         id_alu_op,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [DATA_W-1:0]  ex_rs1_data,
  output logic [DATA_W-1:0]  ex_rs2_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [REG_AW-1:0]  ex_rs1,
  output logic [REG_AW-1:0]  ex_rs2,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [FUNCT_W-1:0] ex_funct,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic               ex_branch,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_alu_src,
  output logic [1:0]         ex_alu_op,
  output logic [CNT_W-1:0]   bubble_count
);

  logic               r_valid;
  logic [DATA_W-1:0]  r_pc;
  logic [DATA_W-1:0]  r_rs1_data;
  logic [DATA_W-1:0]  r_rs2_data;
  logic [DATA_W-1:0]  r_imm;
  logic [REG_AW-1:0]  r_rs1;
  logic [REG_AW-1:0]  r_rs2;
  logic [REG_AW-1:0]  r_rd;
  logic [FUNCT_W-1:0] r_funct;
  ctrl_t              r_ctrl;

  ctrl_t              w_ctrl_in;
  logic               w_load;
  logic               w_bubble;
  logic               w_cnt_hold;

  assign w_ctrl_in = '{reg_write:  id_reg_write,
                       mem_to_reg: id_mem_to_reg,
                       branch:     id_branch,
                       mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       alu_src:    id_alu_src,
                       alu_op:     id_alu_op};

  assign w_load = !flush && !stall;

  // A bubble is either a flush or a load of something that is not an instruction.
  assign w_bubble   = flush || !id_valid;
  assign w_cnt_hold = stall && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_funct    <= '0;
      r_ctrl     <= CTRL_NOP;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_funct    <= '0;
      r_ctrl     <= CTRL_NOP;
    end else if (w_load) begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_funct    <= {id_instr30, id_funct3};
      r_ctrl     <= gate_ctrl(w_ctrl_in, id_valid);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_bubble),
    .hold  (w_cnt_hold),
    .count (bubble_count)
  );

  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_rs1_data   = r_rs1_data;
  assign ex_rs2_data   = r_rs2_data;
  assign ex_imm        = r_imm;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_funct      = r_funct;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_branch     = r_ctrl.branch;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_alu_op     = r_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed hazard scenarios followed by random
// traffic, compared against a record-level model of the stage contents.
module tb_id_ex_stage_reg;
  import core_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // inputs
  logic          stall, flush, id_valid;
  logic [DW-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_instr30;
  logic [2:0]    id_funct3;
  logic          id_reg_write, id_mem_to_reg, id_branch, id_mem_read, id_mem_write, id_alu_src;
  logic [1:0]    id_alu_op;

  // outputs, default-width instance
  logic          ex_valid;
  logic [DW-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0]    ex_funct;
  logic          ex_reg_write, ex_mem_to_reg, ex_branch, ex_mem_read, ex_mem_write, ex_alu_src;
  logic [1:0]    ex_alu_op;
  logic [15:0]   bubble_count;

  // outputs, 4-bit counter instance
  logic          s_valid;
  logic [DW-1:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [AW-1:0] s_rs1, s_rs2, s_rd;
  logic [3:0]    s_funct;
  logic          s_reg_write, s_mem_to_reg, s_branch, s_mem_read, s_mem_write, s_alu_src;
  logic [1:0]    s_alu_op;
  logic [3:0]    s_bubble_count;

  id_ex_stage_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_instr30(id_instr30), .id_funct3(id_funct3),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .bubble_count(bubble_count)
  );

  id_ex_stage_reg #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_instr30(id_instr30), .id_funct3(id_funct3),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data),
    .ex_imm(s_imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct(s_funct),
    .ex_reg_write(s_reg_write), .ex_mem_to_reg(s_mem_to_reg), .ex_branch(s_branch),
    .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write), .ex_alu_src(s_alu_src),
    .ex_alu_op(s_alu_op), .bubble_count(s_bubble_count)
  );

  // reference model: what EX should hold, as one record, plus bubble tallies
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc, rs1_data, rs2_data, imm;
    logic [AW-1:0] rs1, rs2, rd;
    logic [3:0]    funct;
    logic          reg_write, mem_to_reg, branch, mem_read, mem_write, alu_src;
    logic [1:0]    alu_op;
  } ex_rec_t;

  ex_rec_t m_ex;
  int      m_bub16;
  int      m_bub4;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic model_reset();
    m_ex    = '0;
    m_bub16 = 0;
    m_bub4  = 0;
  endtask

  // one rising edge of the stage, from the input values present at that edge
  task automatic model_edge();
    if (flush) begin
      m_ex    = '0;
      m_bub16 = sat_inc(m_bub16, 65535);
      m_bub4  = sat_inc(m_bub4, 15);
    end else if (!stall) begin
      m_ex.valid    = id_valid;
      m_ex.pc       = id_pc;
      m_ex.rs1_data = id_rs1_data;
      m_ex.rs2_data = id_rs2_data;
      m_ex.imm      = id_imm;
      m_ex.rs1      = id_rs1;
      m_ex.rs2      = id_rs2;
      m_ex.rd       = id_rd;
      m_ex.funct    = {id_instr30, id_funct3};
      m_ex.reg_write  = id_valid & id_reg_write;
      m_ex.mem_to_reg = id_valid & id_mem_to_reg;
      m_ex.branch     = id_valid & id_branch;
      m_ex.mem_read   = id_valid & id_mem_read;
      m_ex.mem_write  = id_valid & id_mem_write;
      m_ex.alu_src    = id_valid & id_alu_src;
      m_ex.alu_op     = id_valid ? id_alu_op : 2'b00;
      if (!id_valid) begin
        m_bub16 = sat_inc(m_bub16, 65535);
        m_bub4  = sat_inc(m_bub4, 15);
      end
    end
  endtask

  task automatic check_all();
    check("valid",     ex_valid,      m_ex.valid);
    check("pc",        ex_pc,         m_ex.pc);
    check("rs1_data",  ex_rs1_data,   m_ex.rs1_data);
    check("rs2_data",  ex_rs2_data,   m_ex.rs2_data);
    check("imm",       ex_imm,        m_ex.imm);
    check("rs1",       ex_rs1,        m_ex.rs1);
    check("rs2",       ex_rs2,        m_ex.rs2);
    check("rd",        ex_rd,         m_ex.rd);
    check("funct",     ex_funct,      m_ex.funct);
    check("reg_write", ex_reg_write,  m_ex.reg_write);
    check("mem_to_reg",ex_mem_to_reg, m_ex.mem_to_reg);
    check("branch",    ex_branch,     m_ex.branch);
    check("mem_read",  ex_mem_read,   m_ex.mem_read);
    check("mem_write", ex_mem_write,  m_ex.mem_write);
    check("alu_src",   ex_alu_src,    m_ex.alu_src);
    check("alu_op",    ex_alu_op,     m_ex.alu_op);
    check("bubbles16", bubble_count,  m_bub16);
    check("bubbles4",  s_bubble_count, m_bub4);
    check("small_rec", {s_valid, s_pc, s_rs1_data[15:0], s_funct, s_reg_write, s_mem_write, s_alu_op},
          {m_ex.valid, m_ex.pc, m_ex.rs1_data[15:0], m_ex.funct, m_ex.reg_write, m_ex.mem_write, m_ex.alu_op});
  endtask

  // driver tasks; inputs change only after the falling edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive_instr(input logic [1:0] alu_op, input logic i30, input logic [2:0] f3,
                             input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                             input logic [AW-1:0] rd, input logic [5:0] ctrl);
    id_valid = 1'b1;
    id_pc    = 64'h8000_0000 + {$urandom_range(0, 255), 2'b00};
    id_rs1_data = a;  id_rs2_data = b;
    id_imm   = {$urandom, $urandom};
    id_rs1 = rs1;  id_rs2 = rs2;  id_rd = rd;
    id_instr30 = i30;  id_funct3 = f3;  id_alu_op = alu_op;
    {id_reg_write, id_mem_to_reg, id_branch, id_mem_read, id_mem_write, id_alu_src} = ctrl;
  endtask

  task automatic drive_random();
    flush    = ($urandom_range(0, 9) == 0);
    stall    = ($urandom_range(0, 4) == 0);
    id_valid = ($urandom_range(0, 4) != 0);
    id_pc       = {$urandom, $urandom};
    id_rs1_data = {$urandom, $urandom};
    id_rs2_data = {$urandom, $urandom};
    id_imm      = {$urandom, $urandom};
    id_rs1 = AW'($urandom);  id_rs2 = AW'($urandom);  id_rd = AW'($urandom);
    id_instr30 = 1'($urandom);
    id_funct3  = 3'($urandom);
    {id_reg_write, id_mem_to_reg, id_branch, id_mem_read, id_mem_write, id_alu_src} = 6'($urandom);
    id_alu_op  = 2'($urandom_range(0, 2));
  endtask

  int saved_bub;

  initial begin
    reset = 1'b1;
    stall = 1'b0;  flush = 1'b0;  id_valid = 1'b0;
    drive_instr(2'b00, 1'b0, 3'b000, '0, '0, '0, '0, '0, 6'b0);
    id_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;

    // add x3, x1, x2
    drive_instr(ALUOP_R, 1'b0, 3'b000, 64'd5, 64'd7, 5'd1, 5'd2, 5'd3, 6'b100000);
    tick();
    check("add_funct", ex_funct, 4'b0000);
    check("add_aluop", ex_alu_op, 2'b10);
    check("add_a",     ex_rs1_data, 64'd5);
    check("add_b",     ex_rs2_data, 64'd7);
    check("add_rd",    ex_rd, 5'd3);
    check("add_valid", ex_valid, 1'b1);

    // sub x4, x1, x2
    drive_instr(ALUOP_R, 1'b1, 3'b000, 64'd5, 64'd7, 5'd1, 5'd2, 5'd4, 6'b100000);
    tick();
    check("sub_funct", ex_funct, 4'b1000);

    // stall 3 cycles while slli waits in ID
    stall = 1'b1;
    drive_instr(ALUOP_MEM, 1'b0, 3'b001, 64'd9, 64'd0, 5'd6, 5'd0, 5'd7, 6'b100001);
    repeat (3) begin
      tick();
      check("stall_funct", ex_funct, 4'b1000);
      check("stall_aluop", ex_alu_op, 2'b10);
    end
    stall = 1'b0;
    tick();
    check("slli_funct", ex_funct, 4'b0001);
    check("slli_aluop", ex_alu_op, 2'b00);

    // flush beats stall with a valid sw in ID
    saved_bub = m_bub16;
    flush = 1'b1;  stall = 1'b1;
    drive_instr(ALUOP_MEM, 1'b0, 3'b010, 64'd100, 64'd42, 5'd8, 5'd9, 5'd0, 6'b000011);
    tick();
    check("flush_valid", ex_valid, 1'b0);
    check("flush_memw",  ex_mem_write, 1'b0);
    check("flush_bub",   bubble_count, 16'(saved_bub + 1));
    flush = 1'b0;  stall = 1'b0;

    // invalid slot with live-looking controls
    saved_bub = m_bub16;
    drive_instr(ALUOP_R, 1'b0, 3'b111, 64'hDEAD_BEEF, 64'h1234, 5'd10, 5'd11, 5'd12, 6'b100010);
    id_valid = 1'b0;
    tick();
    check("inv_regw", ex_reg_write, 1'b0);
    check("inv_memw", ex_mem_write, 1'b0);
    check("inv_data", ex_rs1_data, 64'hDEAD_BEEF);
    check("inv_bub",  bubble_count, 16'(saved_bub + 1));

    // reset pulse between edges with outputs loaded
    drive_instr(ALUOP_BR, 1'b0, 3'b001, 64'd1, 64'd2, 5'd1, 5'd2, 5'd0, 6'b001000);
    tick();
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    check("rst_bub", bubble_count, 16'd0);
    reset = 1'b0;

    // saturation of the 4-bit counter
    flush = 1'b1;
    repeat (20) tick();
    check("sat4",  s_bubble_count, 4'd15);
    check("sat16", bubble_count, 16'd20);
    flush = 1'b0;  stall = 1'b1;  id_valid = 1'b0;
    tick();
    check("sat4_stall", s_bubble_count, 4'd15);
    stall = 1'b0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive_random();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
